// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: C = M^E mod P via a constant-time radix-2 Montgomery ladder.
// One bit-serial Montgomery multiplier (WIDTH+1 cycles per product) is reused
// for a fixed schedule of 2*EXP_WIDTH+3 products, so latency never depends on E.
module rsa_modexp_core #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear_irq,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Const,
    output logic                 busy,
    output logic                 eoc,
    output logic                 irq,
    output logic                 err,
    output logic [WIDTH-1:0]     C
);

    localparam int NMUL = 2 * EXP_WIDTH + 3;
    localparam int KW   = $clog2(NMUL + 1);
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MMUL, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       p_q, p_d, m_q, m_d, const_q, const_d;
    logic [EXP_WIDTH-1:0]   e_q, e_d;
    logic [KW-1:0]          k_q, k_d;      // index of the product in the schedule
    logic [CW-1:0]          cyc_q, cyc_d;  // cycle inside one product
    logic [WIDTH+1:0]       t_q, t_d;      // Montgomery accumulator, < 2P
    logic [WIDTH-1:0]       mb_q, mb_d, a_q, a_d, s_q, s_d, res_q, res_d;
    logic [WIDTH-1:0]       c_q, c_d;
    logic                   eoc_q, eoc_d, irq_q, irq_d, err_q, err_d;

    logic [WIDTH-1:0]       op_a, op_b, a_sh, mm_res;
    logic [WIDTH+1:0]       t_add, t_odd, t_sub, p_ext;

    // Operand selection for the current product of the ladder schedule
    always_comb begin
        op_a = a_q;
        op_b = a_q;
        if (k_q == '0) begin
            op_a = m_q;          // Mb = mm(M, R^2): message into Montgomery domain
            op_b = const_q;
        end else if (k_q == KW'(1)) begin
            op_a = ONE;          // A = mm(1, R^2) = R mod P
            op_b = const_q;
        end else if (k_q == KW'(NMUL - 1)) begin
            op_a = a_q;          // leave Montgomery domain
            op_b = ONE;
        end else if (k_q[0]) begin
            op_a = s_q;          // odd slot: X = mm(S, Mb), always executed
            op_b = mb_q;
        end
    end

    // One bit-serial Montgomery step plus the final conditional subtract
    always_comb begin
        p_ext  = {2'b00, p_q};
        a_sh   = op_a >> cyc_q;
        t_add  = t_q + (a_sh[0] ? {2'b00, op_b} : '0);
        t_odd  = t_add + (t_add[0] ? p_ext : '0);
        t_sub  = (t_q >= p_ext) ? (t_q - p_ext) : t_q;
        mm_res = t_sub[WIDTH-1:0];
    end

    // Next-state and datapath update; stop overrides everything except irq clear
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        const_d = const_q;
        k_d     = k_q;
        cyc_d   = cyc_q;
        t_d     = t_q;
        mb_d    = mb_q;
        a_d     = a_q;
        s_d     = s_q;
        res_d   = res_q;
        c_d     = c_q;
        err_d   = err_q;
        eoc_d   = 1'b0;
        irq_d   = clear_irq ? 1'b0 : irq_q;

        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    p_d     = P;
                    e_d     = E;
                    m_d     = M;
                    const_d = Const;
                    err_d   = ~P[0];
                    res_d   = '0;
                    t_d     = '0;
                    cyc_d   = '0;
                    k_d     = '0;
                    state_d = P[0] ? S_MMUL : S_DONE;
                end
                S_MMUL: begin
                    if (cyc_q != CW'(WIDTH)) begin
                        t_d   = t_odd >> 1;
                        cyc_d = cyc_q + CW'(1);
                    end else begin
                        t_d   = '0;
                        cyc_d = '0;
                        k_d   = k_q + KW'(1);
                        if (k_q == '0) begin
                            mb_d = mm_res;
                        end else if (k_q == KW'(1)) begin
                            a_d = mm_res;
                        end else if (k_q == KW'(NMUL - 1)) begin
                            res_d   = mm_res;
                            state_d = S_DONE;
                        end else if (!k_q[0]) begin
                            s_d = mm_res;
                        end else begin
                            a_d = e_q[EXP_WIDTH-1] ? mm_res : s_q;
                            e_d = e_q << 1;
                        end
                    end
                end
                S_DONE: begin
                    c_d     = res_q;
                    eoc_d   = 1'b1;
                    irq_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers, frozen while ena is low
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            const_q <= '0;
            k_q     <= '0;
            cyc_q   <= '0;
            t_q     <= '0;
            mb_q    <= '0;
            a_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
            c_q     <= '0;
            eoc_q   <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            const_q <= const_d;
            k_q     <= k_d;
            cyc_q   <= cyc_d;
            t_q     <= t_d;
            mb_q    <= mb_d;
            a_q     <= a_d;
            s_q     <= s_d;
            res_q   <= res_d;
            c_q     <= c_d;
            eoc_q   <= eoc_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign eoc  = eoc_q;
    assign irq  = irq_q;
    assign err  = err_q;
    assign C    = c_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed cases on an 8-bit core plus a randomized
// regression on 8/16/32-bit cores against a plain square-and-multiply model.
module tb_rsa_modexp_core;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        ena = 1'b1;
    logic        stop = 1'b0;
    logic        clear_irq = 1'b0;
    logic [2:0]  start_v = '0;
    logic [31:0] p_v [3];
    logic [31:0] e_v [3];
    logic [31:0] m_v [3];
    logic [31:0] k_v [3];

    logic        busy8, eoc8, irq8, err8;
    logic        busy16, eoc16, irq16, err16;
    logic        busy32, eoc32, irq32, err32;
    logic [7:0]  c8;
    logic [15:0] c16;
    logic [31:0] c32;
    logic [2:0]  busy_v, eoc_v, irq_v, err_v;
    logic [31:0] c_v [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start_v[0]), .stop(stop),
        .clear_irq(clear_irq), .P(p_v[0][7:0]), .E(e_v[0][7:0]), .M(m_v[0][7:0]),
        .Const(k_v[0][7:0]), .busy(busy8), .eoc(eoc8), .irq(irq8), .err(err8), .C(c8));

    rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start_v[1]), .stop(stop),
        .clear_irq(clear_irq), .P(p_v[1][15:0]), .E(e_v[1][15:0]), .M(m_v[1][15:0]),
        .Const(k_v[1][15:0]), .busy(busy16), .eoc(eoc16), .irq(irq16), .err(err16), .C(c16));

    rsa_modexp_core #(.WIDTH(32), .EXP_WIDTH(32)) dut32 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start_v[2]), .stop(stop),
        .clear_irq(clear_irq), .P(p_v[2]), .E(e_v[2]), .M(m_v[2]),
        .Const(k_v[2]), .busy(busy32), .eoc(eoc32), .irq(irq32), .err(err32), .C(c32));

    assign busy_v = {busy32, busy16, busy8};
    assign eoc_v  = {eoc32, eoc16, eoc8};
    assign irq_v  = {irq32, irq16, irq8};
    assign err_v  = {err32, err16, err8};
    assign c_v[0] = {24'd0, c8};
    assign c_v[1] = {16'd0, c16};
    assign c_v[2] = c32;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        return 8 << sel;
    endfunction

    function automatic int lat_of(input int sel);
        int w;
        w = width_of(sel);
        return 2 + (2 * w + 3) * (w + 1);
    endfunction

    // Reference: plain left-to-right square-and-multiply on integers
    function automatic longint unsigned modexp(input longint unsigned p, input longint unsigned m,
                                               input longint unsigned e, input int ew);
        longint unsigned r;
        r = 64'd1 % p;
        for (int i = ew - 1; i >= 0; i--) begin
            r = (r * r) % p;
            if (((e >> i) & 64'd1) != 0) r = (r * (m % p)) % p;
        end
        return r;
    endfunction

    function automatic longint unsigned r2_of(input longint unsigned p, input int w);
        longint unsigned x;
        x = (64'd1 << w) % p;
        return (x * x) % p;
    endfunction

    // Launch one operation and watch it; optional stop or 20-cycle ena gap
    task automatic run_op(input int sel, input longint unsigned p, input longint unsigned e,
                          input longint unsigned m, input longint unsigned cst,
                          input int stop_at, input int ena_at,
                          output longint unsigned c, output int lat, output int bcnt,
                          output bit err1, output bit done);
        int lim;
        lim = lat_of(sel) + 60;
        p_v[sel] = p[31:0];
        e_v[sel] = e[31:0];
        m_v[sel] = m[31:0];
        k_v[sel] = cst[31:0];
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1 start_v[sel] = 1'b0;
        lat = 0; bcnt = 0; err1 = 1'b0; done = 1'b0;
        while (!done && lat < lim) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 1) err1 = err_v[sel];
            if (eoc_v[sel]) done = 1'b1;
            else if (busy_v[sel]) bcnt++;
            if (stop_at > 0 && lat == stop_at) stop = 1'b1;
            if (stop_at > 0 && lat == stop_at + 1) stop = 1'b0;
            if (ena_at > 0 && lat == ena_at) ena = 1'b0;
            if (ena_at > 0 && lat == ena_at + 20) ena = 1'b1;
        end
        c = c_v[sel];
    endtask

    initial begin
        longint unsigned c, p, m, e, cst, cprev;
        int lat, bcnt;
        bit err1, done;
        for (int i = 0; i < 3; i++) begin
            p_v[i] = '0; e_v[i] = '0; m_v[i] = '0; k_v[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_eoc", eoc8, 0);
        chk("rst_irq", irq8, 0);
        chk("rst_err", err8, 0);
        chk("rst_C", c8, 0);
        @(negedge clk) rstb = 1'b1;
        @(posedge clk); #1;

        // Encrypt reference case
        run_op(0, 187, 7, 88, 86, 0, 0, c, lat, bcnt, err1, done);
        chk("enc_done", done, 1);
        chk("enc_C", c, modexp(187, 88, 7, 8));
        chk("enc_lat", lat, lat_of(0));
        chk("enc_busy_cycles", bcnt, lat_of(0) - 1);
        chk("enc_irq", irq8, 1);
        chk("enc_err", err8, 0);
        @(posedge clk); #1;
        chk("enc_eoc_pulse", eoc8, 0);

        // Decrypt, then E = 0, then irq clear
        run_op(0, 187, 23, 11, 86, 0, 0, c, lat, bcnt, err1, done);
        chk("dec_C", c, modexp(187, 11, 23, 8));
        run_op(0, 187, 0, 11, 86, 0, 0, c, lat, bcnt, err1, done);
        chk("e0_C", c, 1);
        clear_irq = 1'b1;
        @(posedge clk);
        #1 clear_irq = 1'b0;
        chk("irq_clear", irq8, 0);

        // Even modulus error path, then recovery
        run_op(0, 186, 7, 88, 86, 0, 0, c, lat, bcnt, err1, done);
        chk("even_err", err8, 1);
        chk("even_C", c, 0);
        chk("even_lat", lat, 2);
        run_op(0, 187, 7, 88, 86, 0, 0, c, lat, bcnt, err1, done);
        chk("recov_err_after_load", err1, 0);
        chk("recov_C", c, modexp(187, 88, 7, 8));

        // Abort at cycle 50: no eoc, C held, then a clean restart
        cprev = c8;
        clear_irq = 1'b1;
        @(posedge clk);
        #1 clear_irq = 1'b0;
        run_op(0, 187, 23, 11, 86, 50, 0, c, lat, bcnt, err1, done);
        chk("stop_no_eoc", done, 0);
        chk("stop_busy_cycles", bcnt, 50);
        chk("stop_C_held", c, cprev);
        chk("stop_irq_held", irq8, 0);
        run_op(0, 187, 23, 11, 86, 0, 0, c, lat, bcnt, err1, done);
        chk("restart_C", c, modexp(187, 11, 23, 8));
        chk("restart_lat", lat, lat_of(0));

        // ena gap delays eoc by exactly the gap
        run_op(0, 187, 7, 88, 86, 0, 60, c, lat, bcnt, err1, done);
        chk("ena_gap_lat", lat, lat_of(0) + 20);
        chk("ena_gap_C", c, modexp(187, 88, 7, 8));

        // start and stop together in IDLE: nothing happens
        stop = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        stop = 1'b0;
        chk("start_stop_busy", busy8, 0);
        repeat (3) @(posedge clk);
        #1 chk("start_stop_eoc", eoc8, 0);

        // P = 1 boundary
        run_op(0, 1, 5, 0, 0, 0, 0, c, lat, bcnt, err1, done);
        chk("p1_C", c, 0);
        chk("p1_err", err8, 0);

        // Random regression across widths
        for (int sel = 0; sel < 3; sel++) begin
            int w;
            longint unsigned mask;
            w = width_of(sel);
            mask = (64'd1 << w) - 1;
            for (int n = 0; n < 6; n++) begin
                p = ({32'd0, $urandom} & mask) | 64'd1;
                if (p == 1) p = 3;
                m = {32'd0, $urandom} % p;
                e = {32'd0, $urandom} & mask;
                cst = r2_of(p, w);
                run_op(sel, p, e, m, cst, 0, 0, c, lat, bcnt, err1, done);
                chk($sformatf("rnd_w%0d_C", w), c, modexp(p, m, e, w));
                chk($sformatf("rnd_w%0d_lat", w), lat, lat_of(sel));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
